// File: rtl/fp_align_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : fp_align_unit                                                |
// | Description : FP32 add/sub pre-alignment. Unpacks both operands, picks the |
// |               larger magnitude, and right-shifts the smaller significand   |
// |               with guard/round/sticky. Two-stage valid/ready pipeline.     |
// |               Optional NaN/Inf detection: define FP_ALIGN_SPECIAL_EN.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fp_align_unit #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_MAN  = 23,
  parameter int SIZE_DATA = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_DATA-1:0]  i_data_a,
  input  logic [SIZE_DATA-1:0]  i_data_b,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_EXP-1:0]   o_exp_max,
  output logic [SIZE_EXP-1:0]   o_exp_diff,
  output logic [SIZE_MAN+3:0]   o_man_large,
  output logic [SIZE_MAN+3:0]   o_man_small,
  output logic                  o_sign_large,
  output logic                  o_eff_sub,
  output logic                  o_swap,
  output logic                  o_special,
  output logic [SIZE_DATA-1:0]  o_special_result
);

  localparam int                C_MW       = SIZE_MAN + 4;   // significand + G/R/S
  localparam int                C_SW       = SIZE_MAN + 1;   // hidden + fraction
  localparam logic [SIZE_EXP-1:0] C_DIFF_LIM = SIZE_EXP'(C_MW);
  localparam logic [SIZE_EXP-1:0] C_EXP_ONES = '1;

  // Unpacked operand fields
  logic [SIZE_EXP-1:0] exp_a, exp_b, eff_exp_a, eff_exp_b;
  logic [C_SW-1:0]     sig_a, sig_b;
  logic                sign_a, sign_b, swap;

  // Stage-1 registers
  logic                s1_valid_q, s1_valid_d;
  logic [SIZE_EXP-1:0] s1_exp_max_q, s1_exp_max_d, s1_exp_diff_q, s1_exp_diff_d;
  logic [C_SW-1:0]     s1_sig_large_q, s1_sig_large_d, s1_sig_small_q, s1_sig_small_d;
  logic                s1_sign_large_q, s1_sign_large_d, s1_eff_sub_q, s1_eff_sub_d;
  logic                s1_swap_q, s1_swap_d, s1_special_q, s1_special_d;
  logic [SIZE_DATA-1:0] s1_special_res_q, s1_special_res_d;

  // Stage-2 (output) registers
  logic                s2_valid_q, s2_valid_d;
  logic [SIZE_EXP-1:0] s2_exp_max_q, s2_exp_max_d, s2_exp_diff_q, s2_exp_diff_d;
  logic [C_MW-1:0]     s2_man_large_q, s2_man_large_d, s2_man_small_q, s2_man_small_d;
  logic                s2_sign_large_q, s2_sign_large_d, s2_eff_sub_q, s2_eff_sub_d;
  logic                s2_swap_q, s2_swap_d, s2_special_q, s2_special_d;
  logic [SIZE_DATA-1:0] s2_special_res_q, s2_special_res_d;

  logic                s1_adv, s2_adv, s1_load;
  logic                spec_flag;
  logic [SIZE_DATA-1:0] spec_res;
  logic [C_MW-1:0]     man_full, shifted, out_mask, man_small_sh;

  // Handshake: a stage may advance when empty or when its consumer advances
  always_comb begin
    s2_adv  = ~s2_valid_q | i_ready;
    s1_adv  = ~s1_valid_q | s2_adv;
    o_ready = s1_adv;
    s1_load = s1_adv & i_valid;
  end

  // Unpack operands and decide which one is larger in magnitude
  always_comb begin
    exp_a     = i_data_a[SIZE_DATA-2 -: SIZE_EXP];
    exp_b     = i_data_b[SIZE_DATA-2 -: SIZE_EXP];
    eff_exp_a = (exp_a == '0) ? SIZE_EXP'(1) : exp_a;
    eff_exp_b = (exp_b == '0) ? SIZE_EXP'(1) : exp_b;
    sig_a     = {|exp_a, i_data_a[SIZE_MAN-1:0]};
    sig_b     = {|exp_b, i_data_b[SIZE_MAN-1:0]};
    sign_a    = i_data_a[SIZE_DATA-1];
    sign_b    = i_data_b[SIZE_DATA-1] ^ i_sub;
    // Ties leave A as the large operand
    swap      = {eff_exp_b, sig_b} > {eff_exp_a, sig_a};
  end

`ifdef FP_ALIGN_SPECIAL_EN
  logic nan_a, nan_b, inf_a, inf_b;
  // NaN/Inf classification and final special result
  always_comb begin
    nan_a     = (exp_a == C_EXP_ONES) && (i_data_a[SIZE_MAN-1:0] != '0);
    nan_b     = (exp_b == C_EXP_ONES) && (i_data_b[SIZE_MAN-1:0] != '0);
    inf_a     = (exp_a == C_EXP_ONES) && (i_data_a[SIZE_MAN-1:0] == '0);
    inf_b     = (exp_b == C_EXP_ONES) && (i_data_b[SIZE_MAN-1:0] == '0);
    spec_flag = 1'b0;
    spec_res  = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a ^ sign_b))) begin
      spec_flag = 1'b1;
      spec_res  = {1'b0, C_EXP_ONES, 1'b1, {(SIZE_MAN-1){1'b0}}};
    end else if (inf_a) begin
      spec_flag = 1'b1;
      spec_res  = {sign_a, C_EXP_ONES, {SIZE_MAN{1'b0}}};
    end else if (inf_b) begin
      spec_flag = 1'b1;
      spec_res  = {sign_b, C_EXP_ONES, {SIZE_MAN{1'b0}}};
    end
  end
`else
  // Special-value handling disabled: constant zero
  always_comb begin
    spec_flag = 1'b0;
    spec_res  = '0;
  end
`endif

  // Stage-1 next state: load compare results when advancing, else hold
  always_comb begin
    s1_valid_d       = s1_adv ? i_valid : s1_valid_q;
    s1_exp_max_d     = s1_exp_max_q;
    s1_exp_diff_d    = s1_exp_diff_q;
    s1_sig_large_d   = s1_sig_large_q;
    s1_sig_small_d   = s1_sig_small_q;
    s1_sign_large_d  = s1_sign_large_q;
    s1_eff_sub_d     = s1_eff_sub_q;
    s1_swap_d        = s1_swap_q;
    s1_special_d     = s1_special_q;
    s1_special_res_d = s1_special_res_q;
    if (s1_load) begin
      s1_exp_max_d     = swap ? eff_exp_b : eff_exp_a;
      s1_exp_diff_d    = swap ? (eff_exp_b - eff_exp_a) : (eff_exp_a - eff_exp_b);
      s1_sig_large_d   = swap ? sig_b : sig_a;
      s1_sig_small_d   = swap ? sig_a : sig_b;
      s1_sign_large_d  = swap ? sign_b : sign_a;
      s1_eff_sub_d     = sign_a ^ sign_b;
      s1_swap_d        = swap;
      s1_special_d     = spec_flag;
      s1_special_res_d = spec_res;
    end
  end

  // Right shift of the small significand; shifted-out bits fold into sticky
  always_comb begin
    man_full = {s1_sig_small_q, 3'b000};
    out_mask = ~({C_MW{1'b1}} << s1_exp_diff_q);
    shifted  = man_full >> s1_exp_diff_q;
    if (s1_exp_diff_q >= C_DIFF_LIM) begin
      man_small_sh = {{(C_MW-1){1'b0}}, |s1_sig_small_q};
    end else begin
      man_small_sh = {shifted[C_MW-1:1], shifted[0] | (|(man_full & out_mask))};
    end
  end

  // Stage-2 next state: load aligned result when advancing, else hold
  always_comb begin
    s2_valid_d       = s2_adv ? s1_valid_q : s2_valid_q;
    s2_exp_max_d     = s2_exp_max_q;
    s2_exp_diff_d    = s2_exp_diff_q;
    s2_man_large_d   = s2_man_large_q;
    s2_man_small_d   = s2_man_small_q;
    s2_sign_large_d  = s2_sign_large_q;
    s2_eff_sub_d     = s2_eff_sub_q;
    s2_swap_d        = s2_swap_q;
    s2_special_d     = s2_special_q;
    s2_special_res_d = s2_special_res_q;
    if (s2_adv && s1_valid_q) begin
      s2_exp_max_d     = s1_exp_max_q;
      s2_exp_diff_d    = s1_exp_diff_q;
      s2_man_large_d   = {s1_sig_large_q, 3'b000};
      s2_man_small_d   = man_small_sh;
      s2_sign_large_d  = s1_sign_large_q;
      s2_eff_sub_d     = s1_eff_sub_q;
      s2_swap_d        = s1_swap_q;
      s2_special_d     = s1_special_q;
      s2_special_res_d = s1_special_res_q;
    end
  end

  // Pipeline registers; reset clears valids and all data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;       s2_valid_q <= 1'b0;
      s1_exp_max_q <= '0;       s2_exp_max_q <= '0;
      s1_exp_diff_q <= '0;      s2_exp_diff_q <= '0;
      s1_sig_large_q <= '0;     s2_man_large_q <= '0;
      s1_sig_small_q <= '0;     s2_man_small_q <= '0;
      s1_sign_large_q <= 1'b0;  s2_sign_large_q <= 1'b0;
      s1_eff_sub_q <= 1'b0;     s2_eff_sub_q <= 1'b0;
      s1_swap_q <= 1'b0;        s2_swap_q <= 1'b0;
      s1_special_q <= 1'b0;     s2_special_q <= 1'b0;
      s1_special_res_q <= '0;   s2_special_res_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;             s2_valid_q <= s2_valid_d;
      s1_exp_max_q <= s1_exp_max_d;         s2_exp_max_q <= s2_exp_max_d;
      s1_exp_diff_q <= s1_exp_diff_d;       s2_exp_diff_q <= s2_exp_diff_d;
      s1_sig_large_q <= s1_sig_large_d;     s2_man_large_q <= s2_man_large_d;
      s1_sig_small_q <= s1_sig_small_d;     s2_man_small_q <= s2_man_small_d;
      s1_sign_large_q <= s1_sign_large_d;   s2_sign_large_q <= s2_sign_large_d;
      s1_eff_sub_q <= s1_eff_sub_d;         s2_eff_sub_q <= s2_eff_sub_d;
      s1_swap_q <= s1_swap_d;               s2_swap_q <= s2_swap_d;
      s1_special_q <= s1_special_d;         s2_special_q <= s2_special_d;
      s1_special_res_q <= s1_special_res_d; s2_special_res_q <= s2_special_res_d;
    end
  end

  // Output drive straight from stage-2 registers
  always_comb begin
    o_valid          = s2_valid_q;
    o_exp_max        = s2_exp_max_q;
    o_exp_diff       = s2_exp_diff_q;
    o_man_large      = s2_man_large_q;
    o_man_small      = s2_man_small_q;
    o_sign_large     = s2_sign_large_q;
    o_eff_sub        = s2_eff_sub_q;
    o_swap           = s2_swap_q;
    o_special        = s2_special_q;
    o_special_result = s2_special_res_q;
  end

endmodule

`default_nettype wire
